// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: control decode, register file with WB write port,
// load-use/halt/flush handling and an ID/EX register. Optional macro: ID_WB_BYPASS_EN.
module id_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [14:0]       ex_ctrl,
    output logic [REG_AW-1:0] ex_src1,
    output logic [REG_AW-1:0] ex_src2,
    output logic [REG_AW-1:0] ex_dst,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [2:0]        ex_cond,
    output logic [DATA_W-1:0] ex_boff
);

    typedef struct packed {
        logic       regwrite;
        logic       alusrc;
        logic       memenable;
        logic       memwrite;
        logic       memtoreg;
        logic       pcread;
        logic       rdsrc;
        logic       halt;
        logic [1:0] branch;
        logic       alusext;
        logic [3:0] aluop;
    } ctrl_t;

    typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

    state_t            state, state_next;
    ctrl_t             dec, ex_ctrl_q;
    logic [REG_AW-1:0] src1, src2, dst;
    logic [DATA_W-1:0] rdata1, rdata2, imm, boff;
    logic [DATA_W-1:0] regs [2**REG_AW];
    logic              load_use, wb_hazard, hazard, hold, accept;

    // Opcode map: 0-5 ALU reg/reg, 6 ADDI, 7 LI (dst op zext imm8), 8 LW, 9 SW,
    // A cond branch, B JAL (dst <- pc), C JR, F HLT, others NOP.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        dec = '0;
        unique case (in_instr[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                dec.regwrite = 1'b1;
                dec.aluop    = in_instr[15:12];
            end
            4'h6: begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; end
            4'h7: begin
                dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.rdsrc = 1'b1;
                dec.alusext  = 1'b1; dec.aluop  = 4'd6;
            end
            4'h8: begin
                dec.regwrite = 1'b1; dec.alusrc = 1'b1;
                dec.memenable = 1'b1; dec.memtoreg = 1'b1;
            end
            4'h9: begin dec.alusrc = 1'b1; dec.memenable = 1'b1; dec.memwrite = 1'b1; end
            4'hA: begin dec.branch = 2'b01; dec.aluop = 4'd1; end
            4'hB: begin dec.regwrite = 1'b1; dec.pcread = 1'b1; dec.branch = 2'b10; end
            4'hC: begin dec.rdsrc = 1'b1; dec.branch = 2'b10; end
            4'hF: dec.branch = 2'b11;
            default: dec = '0;
        endcase
        dec.halt = (dec.branch == 2'b11);
    end

    assign dst  = REG_AW'(in_instr[11:8]);
    assign src1 = dec.rdsrc ? dst : REG_AW'(in_instr[7:4]);
    assign src2 = (dec.memenable & dec.memwrite) ? dst : REG_AW'(in_instr[3:0]);
    assign imm  = dec.alusext ? {{(DATA_W-8){1'b0}}, in_instr[7:0]}
                              : {{(DATA_W-4){in_instr[3]}}, in_instr[3:0]};
    assign boff = {{(DATA_W-10){in_instr[8]}}, in_instr[8:0], 1'b0};

    always_comb begin
        rdata1 = (src1 == '0) ? '0 : regs[src1];
        rdata2 = (src2 == '0) ? '0 : regs[src2];
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_dst != '0 && wb_dst == src1) rdata1 = wb_data;
        if (wb_we && wb_dst != '0 && wb_dst == src2) rdata2 = wb_data;
`endif
    end

    assign load_use = ex_valid & ex_ctrl_q.memenable & ~ex_ctrl_q.memwrite & (ex_dst != '0)
                    & ((ex_dst == src1) | (ex_dst == src2));
`ifdef ID_WB_BYPASS_EN
    assign wb_hazard = 1'b0;
`else
    // Without write-through the read would see the stale value, so wait one cycle.
    assign wb_hazard = wb_we & (wb_dst != '0) & ((wb_dst == src1) | (wb_dst == src2));
`endif
    assign hazard   = in_valid & ~dec.pcread & (load_use | wb_hazard);
    assign hold     = ex_valid & ~ex_ready;
    // STALL is the bubble cycle; the dependent instruction is taken during it.
    assign in_ready = flush | ((state != HALTED) & ~hazard & (~ex_valid | ex_ready));
    assign accept   = in_valid & in_ready & ~flush;

    // NOTE: the register file is reset explicitly because reset must zero every register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else if (wb_we && wb_dst != '0) begin
            regs[wb_dst] <= wb_data;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN, STALL: begin
                if (flush)                  state_next = RUN;
                else if (accept && dec.halt) state_next = HALTED;
                else if (hazard && !hold)    state_next = STALL;
                else                         state_next = RUN;
            end
            HALTED:  if (flush) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            ex_ctrl_q <= '0;
            ex_src1   <= '0;
            ex_src2   <= '0;
            ex_dst    <= '0;
            ex_data1  <= '0;
            ex_data2  <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
            ex_cond   <= '0;
            ex_boff   <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (hold) begin
            ex_valid <= 1'b1;
        end else if (accept) begin
            ex_valid  <= 1'b1;
            ex_ctrl_q <= dec;
            ex_src1   <= src1;
            ex_src2   <= src2;
            ex_dst    <= dst;
            ex_data1  <= dec.pcread ? in_pc : rdata1;
            ex_data2  <= dec.pcread ? '0 : rdata2;
            ex_imm    <= imm;
            ex_pc     <= in_pc;
            ex_cond   <= in_instr[11:9];
            ex_boff   <= boff;
        end else begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_ctrl = ex_ctrl_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode, load-use stall, WB collision,
// back-pressure, halt/flush and asynchronous reset mid-stall.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, wb_we, ex_valid, ex_ready;
    logic [15:0] in_instr, in_pc, wb_data;
    logic [3:0]  wb_dst, ex_src1, ex_src2, ex_dst;
    logic [14:0] ex_ctrl;
    logic [15:0] ex_data1, ex_data2, ex_imm, ex_pc, ex_boff;
    logic [2:0]  ex_cond;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(16), .REG_AW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dst(ex_dst),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_cond(ex_cond), .ex_boff(ex_boff)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] instr, input logic [15:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        wb_we = 1'b0; wb_dst = '0; wb_data = '0; ex_ready = 1'b1;
        tick(); tick();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_ctrl", ex_ctrl, 0);
        check("rst_ex_data1", ex_data1, 0);
        #2 rst = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        // R3 = 0x1234, R2 = 0x0001 through the writeback port
        tick(); wb_we = 1'b1; wb_dst = 4'd3; wb_data = 16'h1234;
        tick(); wb_dst = 4'd2; wb_data = 16'h0001;
        tick(); wb_we = 1'b0;
        issue(16'h0132, 16'h0010);                 // ADD R1,R3,R2
        #1 check("add_in_ready", in_ready, 1);
        tick();
        check("add_valid", ex_valid, 1);
        check("add_data1", ex_data1, 16'h1234);
        check("add_data2", ex_data2, 16'h0001);
        check("add_dst", ex_dst, 1);
        check("add_ctrl", ex_ctrl, 15'h4000);
        check("add_pc", ex_pc, 16'h0010);

        // Load-use: LW R4,[R5+2] then ADD R6,R4,R4
        issue(16'h8452, 16'h0012);
        tick();
        check("lw_ctrl", ex_ctrl, 15'h7400);
        check("lw_imm", ex_imm, 16'h0002);
        check("lw_src1", ex_src1, 5);
        issue(16'h0644, 16'h0014);
        #1 check("lu_stall_ready", in_ready, 0);
        tick();
        check("lu_bubble", ex_valid, 0);
        #1 check("lu_resume_ready", in_ready, 1);
        tick();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_dst", ex_dst, 6);
        check("lu_add_src1", ex_src1, 4);
        check("lu_add_pc", ex_pc, 16'h0014);

        // Immediates, branch offset, LI, SW
        issue(16'h611F, 16'h0020);                 // ADDI R1,R1,-1
        tick();
        check("addi_imm", ex_imm, 16'hFFFF);
        check("addi_ctrl", ex_ctrl, 15'h6000);
        issue(16'hA5FF, 16'h0022);                 // branch cond=2, offset 0x1FF
        tick();
        check("br_ctrl", ex_ctrl, 15'h0021);
        check("br_cond", ex_cond, 3'd2);
        check("br_boff", ex_boff, 16'hFFFE);
        issue(16'h71A5, 16'h0024);                 // LI R1,0xA5
        tick();
        check("li_ctrl", ex_ctrl, 15'h6116);
        check("li_imm", ex_imm, 16'h00A5);
        check("li_src1", ex_src1, 1);
        issue(16'h9310, 16'h0026);                 // SW R3,[R1+0]
        tick();
        check("sw_ctrl", ex_ctrl, 15'h3800);
        check("sw_src2", ex_src2, 3);
        check("sw_data2", ex_data2, 16'h1234);

        // pcread instruction is never stalled by a load
        issue(16'h8452, 16'h0030);                 // LW R4
        tick();
        issue(16'hB044, 16'h0040);                 // JAL with src fields = R4
        #1 check("jal_no_hazard", in_ready, 1);
        tick();
        check("jal_data1", ex_data1, 16'h0040);
        check("jal_data2", ex_data2, 0);
        check("jal_ctrl", ex_ctrl, 15'h4240);

        // WB of R7 collides with SUB R1,R7,R0
        issue(16'h1170, 16'h0042);
        wb_we = 1'b1; wb_dst = 4'd7; wb_data = 16'hBEEF;
`ifdef ID_WB_BYPASS_EN
        #1 check("wb_ready", in_ready, 1);
        tick(); wb_we = 1'b0;
`else
        #1 check("wb_stall_ready", in_ready, 0);
        tick(); wb_we = 1'b0;
        check("wb_bubble", ex_valid, 0);
        #1 check("wb_resume_ready", in_ready, 1);
        tick();
`endif
        check("wb_valid", ex_valid, 1);
        check("wb_data1", ex_data1, 16'hBEEF);
        check("wb_data2", ex_data2, 0);

        // Back-pressure for three cycles
        issue(16'h0132, 16'h0050);
        tick();
        check("hold_valid0", ex_valid, 1);
        ex_ready = 1'b0;
        issue(16'h1170, 16'h0052);
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_in_ready", in_ready, 0);
            tick();
            check("hold_pc", ex_pc, 16'h0050);
            check("hold_data1", ex_data1, 16'h1234);
            check("hold_valid", ex_valid, 1);
        end
        ex_ready = 1'b1;
        #1 check("hold_release_ready", in_ready, 1);
        tick();
        check("hold_next_pc", ex_pc, 16'h0052);
        check("hold_next_data1", ex_data1, 16'hBEEF);

        // HLT, then flush out of HALTED
        issue(16'hF000, 16'h0060);
        tick();
        check("hlt_valid", ex_valid, 1);
        check("hlt_halt_bit", ex_ctrl[7], 1);
        issue(16'h0132, 16'h0062);
        for (int i = 0; i < 10; i++) begin
            #1 check("halted_in_ready", in_ready, 0);
            tick();
        end
        check("halted_drained", ex_valid, 0);
        flush = 1'b1;
        #1 check("flush_ready", in_ready, 1);
        tick(); flush = 1'b0;
        check("flush_discard", ex_valid, 0);
        #1 check("post_flush_ready", in_ready, 1);
        tick();
        check("post_flush_valid", ex_valid, 1);
        check("post_flush_pc", ex_pc, 16'h0062);
        issue(16'h0132, 16'h0064);
        flush = 1'b1;
        tick(); flush = 1'b0;
        check("flush_kill", ex_valid, 0);

        // Asynchronous reset while in the load-use bubble
        issue(16'h8452, 16'h0070);
        tick();
        issue(16'h0644, 16'h0072);
        tick();
        check("stall_bubble", ex_valid, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_ctrl", ex_ctrl, 0);
        check("arst_imm", ex_imm, 0);
        check("arst_pc", ex_pc, 0);
        check("arst_src1", ex_src1, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check("arst_in_ready", in_ready, 1);
        issue(16'h0132, 16'h0080);
        tick();
        check("arst_regs_valid", ex_valid, 1);
        check("arst_regs_data1", ex_data1, 0);
        check("arst_regs_data2", ex_data2, 0);
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
